// File: rtl/mem_resp_mc.sv
// mem_resp_mc: single-outstanding data-memory responder for the multi-cycle
// controller. Word-organised RAM, programmable wait states, byte/half/word
// stores with lane merge, loads with alignment and sign/zero extension, and
// error flagging for illegal size, misalignment and out-of-range addresses.
// Optional feature macro: MEM_RESP_MISALIGN_EN (misaligned half/word accesses
// become legal; word-crossing accesses take an extra ACCESS_HI cycle).
module mem_resp_mc #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
`ifdef MEM_RESP_MISALIGN_EN
    localparam logic [2:0] S_ACCESS_HI = 3'd4;
`endif

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [31:0]           r_mem [DEPTH];
    logic [2:0]            r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [1:0]            r_size;
    logic                  r_wr;
    logic                  r_sext;
    logic                  r_err;
    logic [31:0]           r_rdata;
    logic                  r_resp_err;

    logic                  w_size_bad;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]            w_off;
    logic [3:0]            w_be_lo;
    logic [31:0]           w_wd_lo;
    logic [31:0]           w_rd_lo;

    // Lane mask of an access before it is shifted to its byte offset.
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Align a little-endian word pair to the access offset, then truncate
    // to the access size and extend.
    function automatic logic [31:0] ld_fmt(input logic [63:0] pair, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sext);
        logic [31:0] w;
        w = 32'(pair >> {off, 3'b000});
        case (sz)
            2'b00:   return {{24{sext & w[7]}}, w[7:0]};
            2'b01:   return {{16{sext & w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign w_size_bad = (req_size == 2'b11);

`ifdef MEM_RESP_MISALIGN_EN
    logic [1:0]            w_span;
    logic [32:0]           w_last;
    logic [7:0]            w_be8;
    logic [63:0]           w_wd8;
    logic                  w_cross;
    logic [ADDR_WIDTH-1:0] w_idx_hi;
    logic [31:0]           w_rd_hi;
    logic [31:0]           r_lo;

    // The last byte touched must be in range, which also covers the upper
    // word of a crossing access.
    assign w_span   = (req_size == 2'b00) ? 2'd0 : (req_size == 2'b01) ? 2'd1 : 2'd3;
    assign w_last   = {1'b0, req_addr} + 33'(w_span);
    assign w_err    = w_size_bad | (|(w_last >> (ADDR_WIDTH + 2)));

    // Eight-lane view over the addressed word and the next one.
    assign w_be8    = {4'b0000, size_mask(r_size)} << w_off;
    assign w_wd8    = {32'b0, r_wdata} << {w_off, 3'b000};
    assign w_cross  = |w_be8[7:4];
    assign w_be_lo  = w_be8[3:0];
    assign w_wd_lo  = w_wd8[31:0];
    assign w_idx_hi = w_idx + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign w_rd_hi  = r_mem[w_idx_hi];
`else
    logic w_misal;

    assign w_misal = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_err   = w_size_bad | w_misal | (|(req_addr >> (ADDR_WIDTH + 2)));

    // Aligned accesses only: replicate the store data into every lane so the
    // enabled lanes always carry the right bytes.
    assign w_be_lo = size_mask(r_size) << w_off;
    assign w_wd_lo = (r_size == 2'b00) ? {4{r_wdata[7:0]}} :
                     (r_size == 2'b01) ? {2{r_wdata[15:0]}} : r_wdata;
`endif

    assign w_idx   = r_addr[ADDR_WIDTH+1:2];
    assign w_off   = r_addr[1:0];
    assign w_rd_lo = r_mem[w_idx];

    // RAM write port: addressed-word lanes in ACCESS, next-word lanes in ACCESS_HI.
    always_ff @(posedge clk) begin
        if (r_wr && !r_err) begin
            if (r_state == S_ACCESS) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_be_lo[i]) r_mem[w_idx][8*i +: 8] <= w_wd_lo[8*i +: 8];
                end
            end
`ifdef MEM_RESP_MISALIGN_EN
            if (r_state == S_ACCESS_HI) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_be8[4+i]) r_mem[w_idx_hi][8*i +: 8] <= w_wd8[32+8*i +: 8];
                end
            end
`endif
        end
    end

    // Request capture on acceptance; these are pure data and need no reset.
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && req_valid) begin
            r_addr  <= req_addr[ADDR_WIDTH+1:0];
            r_wdata <= req_wdata;
            r_size  <= req_size;
            r_wr    <= req_wr;
            r_sext  <= req_sext;
            r_err   <= w_err;
        end
`ifdef MEM_RESP_MISALIGN_EN
        if (r_state == S_ACCESS) r_lo <= w_rd_lo;
`endif
    end

    // Control FSM, wait counter and registered response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_rdata    <= 32'd0;
            r_resp_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_state <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                        r_cnt   <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= S_ACCESS;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_ACCESS: begin
`ifdef MEM_RESP_MISALIGN_EN
                    if (w_cross && !r_err) begin
                        r_state <= S_ACCESS_HI;
                    end else
`endif
                    begin
                        r_state    <= S_RESP;
                        r_rdata    <= (r_wr || r_err) ? 32'd0 :
                                      ld_fmt({32'd0, w_rd_lo}, w_off, r_size, r_sext);
                        r_resp_err <= r_err;
                    end
                end
`ifdef MEM_RESP_MISALIGN_EN
                S_ACCESS_HI: begin
                    r_state    <= S_RESP;
                    r_rdata    <= r_wr ? 32'd0 : ld_fmt({w_rd_hi, r_lo}, w_off, r_size, r_sext);
                    r_resp_err <= 1'b0;
                end
`endif
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_mem_resp_mc.sv
// Self-checking bench for mem_resp_mc: table of request vectors with a
// response scoreboard, plus hand-written busy-profile, hold and reset-abort
// sequences. Misaligned-access vectors are used when MEM_RESP_MISALIGN_EN is set.
module tb_mem_resp_mc;

    localparam int AW = 10;
    localparam int WC = 1;
`ifdef MEM_RESP_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sext;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    mem_resp_mc #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_sext(req_sext), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          lat;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
    endtask

    function automatic vec_t mk(input string nm, input logic wr, input logic [31:0] a,
                                input logic [31:0] d, input logic [1:0] sz, input logic sx,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.name = nm; v.wr = wr; v.addr = a; v.wdata = d; v.size = sz; v.sext = sx;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Accept-to-response latency; a word-crossing legal access adds one cycle.
    function automatic int exp_lat(input logic [31:0] a, input logic [1:0] sz, input logic e);
        int lat;
        int nb;
        lat = WC + 2;
        nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        if (MIS && !e && (int'(a[1:0]) + nb > 4)) lat++;
        return lat;
    endfunction

    // Response monitor: every resp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && resp_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: resp_valid=1 actual, required 0 with nothing outstanding");
            end else begin
                e = sb.pop_front();
                chk({e.name, "_rdata"}, resp_rdata, e.rdata);
                chk({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
                chk({e.name, "_lat"}, 32'(cyc - e.cyc), 32'(e.lat));
            end
        end
    end

    task automatic do_req(input vec_t v);
        int   t;
        exp_t e;
        @(negedge clk);
        t = 0;
        while (!req_ready && t < 100) begin @(negedge clk); t++; end
        if (!req_ready) begin
            n_checks++;
            $display("FAIL %s_ready_timeout: req_ready=0 actual, required 1", v.name);
            return;
        end
        req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
        req_size = v.size; req_sext = v.sext; req_valid = 1'b1;
        e.name = v.name; e.rdata = v.exp_rdata; e.err = v.exp_err;
        e.cyc = cyc; e.lat = exp_lat(v.addr, v.size, v.exp_err);
        sb.push_back(e);
        @(negedge clk);
        // Request fields must be ignored once the access is under way.
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_size  = 2'($urandom);
        req_wr    = 1'($urandom);
        req_sext  = 1'($urandom);
        t = 0;
        while (sb.size() != 0 && t < 100) begin @(negedge clk); t++; end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL %s_resp_timeout: no resp_valid within 100 cycles, required one", v.name);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wdata = '0; req_size = 2'b00; req_sext = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);

        // First store with the busy/ready profile watched cycle by cycle.
        req_wr = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        req_size = 2'b10; req_sext = 1'b0; req_valid = 1'b1;
        sb.push_back('{name: "stw10", rdata: 32'd0, err: 1'b0, cyc: cyc, lat: WC + 2});
        for (int i = 1; i <= WC + 3; i++) begin
            @(negedge clk);
            if (i == 1) req_valid = 1'b0;
            chk($sformatf("busy_c%0d", i), {31'd0, busy}, 32'(i <= WC + 2));
            chk($sformatf("ready_c%0d", i), {31'd0, req_ready}, 32'(i > WC + 2));
        end

        tbl.push_back(mk("ldb13s",    0, 32'h13,       32'h0,        2'b00, 1, 32'hFFFFFFDE, 0));
        tbl.push_back(mk("ldb13z",    0, 32'h13,       32'h0,        2'b00, 0, 32'h000000DE, 0));
        tbl.push_back(mk("ldh10s",    0, 32'h10,       32'h0,        2'b01, 1, 32'hFFFFBEEF, 0));
        tbl.push_back(mk("ldh12z",    0, 32'h12,       32'h0,        2'b01, 0, 32'h0000DEAD, 0));
        tbl.push_back(mk("ldb10s",    0, 32'h10,       32'h0,        2'b00, 1, 32'hFFFFFFEF, 0));
        tbl.push_back(mk("stb11",     1, 32'h11,       32'hABCDEF55, 2'b00, 0, 32'h0,        0));
        tbl.push_back(mk("ldb11s",    0, 32'h11,       32'h0,        2'b00, 1, 32'h00000055, 0));
        tbl.push_back(mk("ldw10a",    0, 32'h10,       32'h0,        2'b10, 0, 32'hDEAD55EF, 0));
        tbl.push_back(mk("sth12",     1, 32'h12,       32'hFFFF1234, 2'b01, 0, 32'h0,        0));
        tbl.push_back(mk("ldw10b",    0, 32'h10,       32'h0,        2'b10, 0, 32'h123455EF, 0));
        tbl.push_back(mk("stw20",     1, 32'h20,       32'hCAFEF00D, 2'b10, 0, 32'h0,        0));
        tbl.push_back(mk("stw00",     1, 32'h0,        32'h0,        2'b10, 0, 32'h0,        0));
        tbl.push_back(mk("stw30",     1, 32'h30,       32'h0,        2'b10, 0, 32'h0,        0));
`ifndef MEM_RESP_MISALIGN_EN
        tbl.push_back(mk("e_stw22",   1, 32'h22,       32'h11111111, 2'b10, 0, 32'h0,        1));
        tbl.push_back(mk("e_sth23",   1, 32'h23,       32'h00004444, 2'b01, 0, 32'h0,        1));
`endif
        tbl.push_back(mk("e_st_sz3",  1, 32'h20,       32'h22222222, 2'b11, 0, 32'h0,        1));
        tbl.push_back(mk("ldh22s",    0, 32'h22,       32'h0,        2'b01, 1, 32'hFFFFCAFE, 0));
`ifndef MEM_RESP_MISALIGN_EN
        tbl.push_back(mk("e_ldh21",   0, 32'h21,       32'h0,        2'b01, 1, 32'h0,        1));
`endif
        tbl.push_back(mk("ldb21z",    0, 32'h21,       32'h0,        2'b00, 0, 32'h000000F0, 0));
        tbl.push_back(mk("e_ld_sz3",  0, 32'h20,       32'h0,        2'b11, 0, 32'h0,        1));
        tbl.push_back(mk("ldw20a",    0, 32'h20,       32'h0,        2'b10, 0, 32'hCAFEF00D, 0));
        tbl.push_back(mk("e_stw1000", 1, 32'h1000,     32'h33333333, 2'b10, 0, 32'h0,        1));
        tbl.push_back(mk("e_ldw1000", 0, 32'h1000,     32'h0,        2'b10, 0, 32'h0,        1));
        tbl.push_back(mk("ldb23s",    0, 32'h23,       32'h0,        2'b00, 1, 32'hFFFFFFCA, 0));
        tbl.push_back(mk("e_ldw_ffe", 0, 32'hFFE,      32'h0,        2'b10, 0, 32'h0,        1));
        tbl.push_back(mk("e_ldb_hi",  0, 32'h80000000, 32'h0,        2'b00, 0, 32'h0,        1));
        tbl.push_back(mk("ldw20b",    0, 32'h20,       32'h0,        2'b10, 0, 32'hCAFEF00D, 0));
        tbl.push_back(mk("ldw00",     0, 32'h0,        32'h0,        2'b10, 0, 32'h0,        0));
        for (int k = 0; k < tbl.size(); k++) do_req(tbl[k]);

        // Response data holds after the pulse.
        do_req(mk("ldw10c", 0, 32'h10, 32'h0, 2'b10, 0, 32'h123455EF, 0));
        repeat (2) @(negedge clk);
        chk("hold_rdata", resp_rdata, 32'h123455EF);
        chk("hold_resp_valid", {31'd0, resp_valid}, 32'd0);

        // Reset during WAIT aborts a store before its RAM write.
        @(negedge clk);
        req_wr = 1'b1; req_addr = 32'h30; req_wdata = 32'hAAAAAAAA;
        req_size = 2'b10; req_sext = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_busy_wait", {31'd0, busy}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_rdata", resp_rdata, 32'd0);
        chk("abort_err", {31'd0, resp_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_req(mk("ldw30", 0, 32'h30, 32'h0, 2'b10, 0, 32'h0, 0));

`ifdef MEM_RESP_MISALIGN_EN
        do_req(mk("stw40", 1, 32'h40, 32'h11223344, 2'b10, 0, 32'h0, 0));
        do_req(mk("stw44", 1, 32'h44, 32'h55667788, 2'b10, 0, 32'h0, 0));
        do_req(mk("ldw42x", 0, 32'h42, 32'h0, 2'b10, 0, 32'h77881122, 0));
        do_req(mk("sth43x", 1, 32'h43, 32'h0000ABCD, 2'b01, 0, 32'h0, 0));
        do_req(mk("ldw40", 0, 32'h40, 32'h0, 2'b10, 0, 32'hCD223344, 0));
        do_req(mk("ldw44", 0, 32'h44, 32'h0, 2'b10, 0, 32'h556677AB, 0));
        do_req(mk("ldh43s", 0, 32'h43, 32'h0, 2'b01, 1, 32'hFFFFABCD, 0));
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
